axis_delay_ctrl: RTL and testbench



---
 rtl/axis_delay_ctrl.sv | 138 +++++++++++++
 tb/tb_axis_delay_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_delay_ctrl.sv
// axis_delay_ctrl
//   Flow controller for a fixed-latency, enable-gated delay pipeline. It
//   tracks a valid bit and a last bit through every stage of the controlled
//   datapath, stalls every stage together under output backpressure, and
//   keeps packets apart by refusing new input until the current packet's
//   last beat has left.
//
// Parameters
//   Latency   number of register stages in the controlled pipeline (>= 1)
//   CntWidth  derived width of the in-flight beat counter
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   s_valid_i   upstream beat valid
//   s_last_i    upstream beat is the last of its packet
//   s_ready_o   controller accepts an upstream beat
//   m_valid_o   beat valid at the pipeline output
//   m_last_o    output beat is the last of its packet
//   m_ready_i   downstream accepts the output beat
//   en_o        shared stage enable for the datapath delay registers
//   inflight_o  number of valid beats currently in the pipeline
//   busy_o      high whenever the controller is not IDLE
module axis_delay_ctrl #(
  parameter int Latency = 4,
  localparam int CntWidth = $clog2(Latency + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s_valid_i,
  input  logic                s_last_i,
  output logic                s_ready_o,
  output logic                m_valid_o,
  output logic                m_last_o,
  input  logic                m_ready_i,
  output logic                en_o,
  output logic [CntWidth-1:0] inflight_o,
  output logic                busy_o
);

  generate
    if (Latency < 1) begin : g_bad_latency
      $error("axis_delay_ctrl: Latency must be at least 1");
    end
  endgenerate

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(Latency);

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  // Index 0 is stage 1 (first register), index Latency-1 is the output stage.
  logic [Latency-1:0]  vld_q;
  logic [Latency-1:0]  lst_q;
  logic [CntWidth-1:0] cnt_q;
  logic                en;
  logic                in_fire;
  logic                out_fire;

  assign m_valid_o = vld_q[Latency-1];
  assign m_last_o  = lst_q[Latency-1] & vld_q[Latency-1];

  // The whole pipeline moves only when the output stage is empty or being
  // taken; reset forces the enable low so nothing moves while it is held.
  assign en        = ~rst_i & (~m_valid_o | m_ready_i);
  assign en_o      = en;
  assign s_ready_o = en & (state_q != DRAIN);

  assign in_fire  = s_valid_i & s_ready_o;
  assign out_fire = m_valid_o & m_ready_i;

  // Shadow valid/last shift registers. Bubble stages shift like any other.
  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples its neighbour's pre-edge value, regardless of statement order.
  // NOTE: these are control bits, not datapath storage, so they take the
  // async reset; the matching data registers are reset by their owner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_fire;
      lst_q[0] <= s_last_i;
      for (int i = 1; i < Latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
    end
  end

  // Packet state: DRAIN blocks input from the accept of a last beat until
  // that beat has left, so the next packet starts one cycle after it.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire) state_d = s_last_i ? DRAIN : ACTIVE;
      ACTIVE:  if (in_fire && s_last_i) state_d = DRAIN;
      DRAIN:   if (out_fire && m_last_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // In-flight beat counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign inflight_o = cnt_q;
  assign busy_o     = (state_q != IDLE);

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(in_fire && !out_fire && cnt_q == MaxCnt));

  a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(out_fire && !in_fire && cnt_q == '0));

endmodule

// File: tb/tb_axis_delay_ctrl.sv
// tb_axis_delay_ctrl
//   Self-checking bench for axis_delay_ctrl (Latency = 4). A negedge monitor
//   keeps a scoreboard of accepted beats: each entry holds the beat's last
//   flag, its accept cycle and the stall count at accept, and is popped and
//   compared when the beat leaves the pipeline. Directed sequences cover the
//   single-beat packet, streaming, backpressure, bubbles, packet isolation
//   and asynchronous reset mid-packet.
module tb_axis_delay_ctrl;

  localparam int L = 4;

  logic       clk_i;
  logic       rst_i;
  logic       s_valid_i;
  logic       s_last_i;
  logic       s_ready_o;
  logic       m_valid_o;
  logic       m_last_o;
  logic       m_ready_i;
  logic       en_o;
  logic [2:0] inflight_o;
  logic       busy_o;

  axis_delay_ctrl #(.Latency(L)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s_valid_i  (s_valid_i),
    .s_last_i   (s_last_i),
    .s_ready_o  (s_ready_o),
    .m_valid_o  (m_valid_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i),
    .en_o       (en_o),
    .inflight_o (inflight_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic last;
    int   t_acc;
    int   stalls_at;
  } beat_t;

  beat_t sb[$];
  beat_t e;
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    cyc       = 0;
  int    stall_cnt = 0;
  int    peak      = 0;
  bit    mon_en    = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare outputs first, then record new accepts,
  // then note whether this cycle's edge will be a stall.
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("inflight", int'(inflight_o), sb.size());
      if (sb.size() == 0) check("idle_m_valid", int'(m_valid_o), 0);
      if (m_valid_o && m_ready_i && sb.size() > 0) begin
        e = sb.pop_front();
        check("out_last", int'(m_last_o), int'(e.last));
        check("out_cycle", cyc, e.t_acc + L + (stall_cnt - e.stalls_at));
      end
      if (s_valid_i && s_ready_o) begin
        sb.push_back('{last: s_last_i, t_acc: cyc, stalls_at: stall_cnt});
      end
      if (int'(inflight_o) > peak) peak = int'(inflight_o);
      if (!en_o) stall_cnt++;
    end
  end

  // Offer one beat until it is accepted; returns the accept cycle.
  task automatic send_beat(input logic last, output int t_acc);
    int waited;
    waited = 0;
    t_acc  = -1;
    s_valid_i = 1'b1;
    s_last_i  = last;
    forever begin
      @(negedge clk_i);
      if (s_ready_o) begin
        t_acc = cyc;
        break;
      end
      waited++;
      if (waited > 200) break;
    end
    check("accept_seen", int'(t_acc >= 0), 1);
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  // Wait for an output fire carrying last; returns its cycle.
  task automatic wait_out_last(output int t_out);
    t_out = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (m_valid_o && m_ready_i && m_last_o) begin
        t_out = cyc;
        break;
      end
    end
    check("out_last_seen", int'(t_out >= 0), 1);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, ta, tb, tout;

    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    m_ready_i = 1'b1;

    // Reset state: everything forced low while rst_i is held.
    #3;
    check("rst_s_ready",  int'(s_ready_o),  0);
    check("rst_en",       int'(en_o),       0);
    check("rst_m_valid",  int'(m_valid_o),  0);
    check("rst_m_last",   int'(m_last_o),   0);
    check("rst_busy",     int'(busy_o),     0);
    check("rst_inflight", int'(inflight_o), 0);
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_s_ready", int'(s_ready_o), 1);
    check("post_rst_en",      int'(en_o),      1);
    check("post_rst_busy",    int'(busy_o),    0);
    mon_en = 1'b1;
    next_cycle();

    // 1) single-beat packet
    send_beat(1'b1, t0);
    @(negedge clk_i);
    check("t1_ready_drops", int'(s_ready_o), 0);
    check("t1_busy",        int'(busy_o),    1);
    wait_out_last(tout);
    check("t1_latency", tout - t0, L);
    next_cycle();
    @(negedge clk_i);
    check("t1_ready_back", int'(s_ready_o), 1);
    check("t1_idle",       int'(busy_o),    0);
    next_cycle();

    // 2) six beats back to back
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      send_beat(i == 5, t1);
      if (i == 0) t0 = t1;
    end
    check("t2_one_per_cycle", t1 - t0, 5);
    wait_out_last(tout);
    check("t2_last_latency", tout - t1, L);
    check("t2_peak", peak, L);
    next_cycle();

    // 3) full pipeline, three cycles of backpressure
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(i == 7, t1);
      end
      begin
        int guard;
        guard = 0;
        do begin
          @(negedge clk_i);
          guard++;
        end while (inflight_o != 3'(L) && guard < 100);
        check("t3_full_reached", int'(inflight_o), L);
        next_cycle();
        m_ready_i = 1'b0;
        repeat (3) begin
          @(negedge clk_i);
          check("t3_en_stall",    int'(en_o),       0);
          check("t3_ready_stall", int'(s_ready_o),  0);
          check("t3_inflight",    int'(inflight_o), L);
        end
        next_cycle();
        m_ready_i = 1'b1;
      end
    join
    wait_out_last(tout);
    next_cycle();

    // 4) valid toggling inside a packet
    for (int i = 0; i < 4; i++) begin
      send_beat(i == 3, t1);
      if (i < 3) next_cycle();
    end
    wait_out_last(tout);
    check("t4_last_latency", tout - t1, L);
    next_cycle();

    // 5) two packets offered back to back
    send_beat(1'b0, t1);
    send_beat(1'b1, ta);
    send_beat(1'b0, tb);
    check("t5_isolation", tb - ta, L + 1);
    send_beat(1'b1, t1);
    wait_out_last(tout);
    next_cycle();

    // 6) asynchronous reset with three beats in flight
    for (int i = 0; i < 3; i++) send_beat(1'b0, t1);
    @(posedge clk_i);
    #2;
    check("t6_pre_inflight", int'(inflight_o), 3);
    rst_i = 1'b1;
    sb.delete();
    #1;
    check("t6_m_valid",  int'(m_valid_o),  0);
    check("t6_m_last",   int'(m_last_o),   0);
    check("t6_s_ready",  int'(s_ready_o),  0);
    check("t6_en",       int'(en_o),       0);
    check("t6_inflight", int'(inflight_o), 0);
    check("t6_busy",     int'(busy_o),     0);
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;
    #1;
    check("t6_rel_s_ready",  int'(s_ready_o),  1);
    check("t6_rel_en",       int'(en_o),       1);
    check("t6_rel_busy",     int'(busy_o),     0);
    check("t6_rel_inflight", int'(inflight_o), 0);
    repeat (8) @(negedge clk_i);

    check("sb_empty", sb.size(), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
